// File: rtl/xor_frame_accum.sv
// Purpose: XOR-folds a WIDTH-bit word stream, framed by in_last, into one checksum word per frame; optional macro XOR_ACCUM_PARITY_EN adds out_parity.
// Latency: last word accepted on edge N -> out_valid high from edge N (visible cycle N+1); min one HOLD cycle between frames.
// Backpressure: in_ready drops while a result is held; the result stays stable until out_valid & out_ready.
module xor_frame_accum #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
`ifdef XOR_ACCUM_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             acc_fire;
    logic             out_fire;

    // Ready/valid are pure decodes of the registered state: no out_ready -> in_ready path.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign acc_fire  = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Outputs expose the live registers; they only carry meaning while out_valid is high.
    assign out_data  = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

`ifdef XOR_ACCUM_PARITY_EN
    // Parity of the held checksum; acc clears on reset so this reads 0 then.
    assign out_parity = ^acc;
`endif

    // Frame FSM: fold accepted words, saturate the beat count, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_fire) begin
                        acc   <= in_data;
                        cnt   <= CNT_W'(1);
                        // A first beat can only overflow a zero-length limit.
                        ovf   <= (MAX_LEN == 0);
                        state <= in_last ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (acc_fire) begin
                        acc <= acc ^ in_data;
                        // Beyond MAX_LEN the word is still folded in but only flagged, not counted.
                        if (cnt == CNT_W'(MAX_LEN)) begin
                            ovf <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (in_last) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_frame_accum.sv
// Purpose: self-checking bench for xor_frame_accum with MAX_LEN=4 so overflow is reachable.
// Latency: checks out_valid the cycle after the last beat and in_ready back one cycle later.
// Backpressure: holds out_ready low to verify the result and in_ready stay frozen.
module tb_xor_frame_accum;

    localparam int TB_W     = 8;
    localparam int TB_MAX   = 4;
    localparam int TB_CNT_W = $clog2(TB_MAX + 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [TB_W-1:0]     in_data = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [TB_W-1:0]     out_data;
    logic [TB_CNT_W-1:0] out_count;
    logic                out_ovf;
`ifdef XOR_ACCUM_PARITY_EN
    logic                out_parity;
`endif

    xor_frame_accum #(.WIDTH(TB_W), .MAX_LEN(TB_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
`ifdef XOR_ACCUM_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TB_W-1:0]     data;
        logic [TB_CNT_W-1:0] count;
        logic                ovf;
    } exp_t;

    typedef struct packed {
        logic [3:0]          len;
        logic [7:0][7:0]     words;   // words[0] is the first beat
        logic                gap;     // idle cycle after the first beat
        logic [TB_W-1:0]     e_data;
        logic [TB_CNT_W-1:0] e_count;
        logic                e_ovf;
    } vec_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard: a result is consumed on the edge after a negedge that sees valid & ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got 0x%0h want none", out_data);
            end else begin
                e_mon = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e_mon.data));
                check("out_count", 32'(out_count), 32'(e_mon.count));
                check("out_ovf", 32'(out_ovf), 32'(e_mon.ovf));
`ifdef XOR_ACCUM_PARITY_EN
                check("out_parity", 32'(out_parity), 32'(^e_mon.data));
`endif
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the edge that accepted the word.
    task automatic send_word(input logic [7:0] d, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [TB_CNT_W-1:0] c, input logic o);
        exp_t e;
        e.data  = d;
        e.count = c;
        e.ovf   = o;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{len: 4'd3, words: 64'h0000_0000_003C_F00F, gap: 1'b0, e_data: 8'hC3, e_count: 3'd3, e_ovf: 1'b0};
        tbl[1] = '{len: 4'd1, words: 64'h0000_0000_0000_00A5, gap: 1'b0, e_data: 8'hA5, e_count: 3'd1, e_ovf: 1'b0};
        tbl[2] = '{len: 4'd6, words: 64'h0000_0605_0403_0201, gap: 1'b0, e_data: 8'h07, e_count: 3'd4, e_ovf: 1'b1};
        tbl[3] = '{len: 4'd1, words: 64'h0000_0000_0000_00FF, gap: 1'b0, e_data: 8'hFF, e_count: 3'd1, e_ovf: 1'b0};
        tbl[4] = '{len: 4'd3, words: 64'h0000_0000_005A_0000, gap: 1'b1, e_data: 8'h5A, e_count: 3'd3, e_ovf: 1'b0};
        tbl[5] = '{len: 4'd4, words: 64'h0000_0000_0804_0201, gap: 1'b0, e_data: 8'h0F, e_count: 3'd4, e_ovf: 1'b0};
        tbl[6] = '{len: 4'd5, words: 64'h0000_00FF_55AA_55AA, gap: 1'b1, e_data: 8'hFF, e_count: 3'd4, e_ovf: 1'b1};

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);

        // Table of frames with the sink always ready
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            push_exp(tbl[v].e_data, tbl[v].e_count, tbl[v].e_ovf);
            for (int i = 0; i < int'(tbl[v].len); i++) begin
                send_word(tbl[v].words[i], (i == int'(tbl[v].len) - 1));
                if (tbl[v].gap && i == 0) next_cycle();
            end
            check("lat_out_valid", 32'(out_valid), 32'd1);
            check("lat_in_ready_low", 32'(in_ready), 32'd0);
            next_cycle();
            check("post_out_valid", 32'(out_valid), 32'd0);
            check("post_in_ready", 32'(in_ready), 32'd1);
        end

        // Backpressure: result frozen, pending source word ignored
        out_ready = 1'b0;
        push_exp(8'h03, 3'd2, 1'b0);
        send_word(8'h01, 1'b0);
        send_word(8'h02, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        push_exp(8'h77, 3'd1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'h03);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        check("bp_released_valid", 32'(out_valid), 32'd0);
        check("bp_released_ready", 32'(in_ready), 32'd1);
        check("bp_sb_one_fire", 32'(sb.size()), 32'd1);
        next_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_new_accepted", 32'(out_valid), 32'd1);
        next_cycle();

        // Reset mid-frame discards the partial checksum
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        push_exp(8'h55, 3'd1, 1'b0);
        send_word(8'h55, 1'b1);
        next_cycle();

        // Reset while holding a result: no output pulse afterwards
        out_ready = 1'b0;
        send_word(8'h3C, 1'b1);
        check("hold_before_rst", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        check("hold_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        check("hold_rst_no_pulse", 32'(out_valid), 32'd0);

`ifdef XOR_ACCUM_PARITY_EN
        // Parity of the held word
        out_ready = 1'b0;
        send_word(8'h07, 1'b1);
        check("parity_07", 32'(out_parity), 32'd1);
        push_exp(8'h07, 3'd1, 1'b0);
        out_ready = 1'b1;
        next_cycle();
        send_word(8'h03, 1'b1);
        check("parity_03", 32'(out_parity), 32'd0);
        push_exp(8'h03, 3'd1, 1'b0);
        next_cycle();
`endif

        // Every expected result must have been produced
        begin
            int t = 0;
            while (sb.size() != 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("sb_drained", 32'(sb.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
